// File: rtl/puf_xor_eval_ctrl_if.sv
// puf_xor_eval_ctrl_if: start/status, PUF array pins and byte stream of the XOR PUF evaluation controller
interface puf_xor_eval_ctrl_if #(parameter int WIDTH = 128);
  logic start, busy, done;
  logic puf_i1, puf_i2, puf_rn;
  logic [WIDTH-1:0] puf_out;
  logic [7:0] data_out;
  logic data_valid, data_ready;
  modport master(
    input start, puf_out, data_ready,
    output busy, done, puf_i1, puf_i2, puf_rn, data_out, data_valid
  );
  modport slave(
    output start, puf_out, data_ready,
    input busy, done, puf_i1, puf_i2, puf_rn, data_out, data_valid
  );
endinterface

// File: rtl/puf_xor_eval_ctrl.sv
// puf_xor_eval_ctrl: clears and fires the XOR PUF array, captures the response and streams it out LSB byte first
module puf_xor_eval_ctrl #(
  parameter int WIDTH      = 128,
  parameter int RST_CYC    = 4,
  parameter int SETTLE_CYC = 8
) (
  input logic clk,
  input logic rst,
  puf_xor_eval_ctrl_if.master bus
);
  localparam int NB = WIDTH / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int CW = $clog2(RST_CYC + SETTLE_CYC + 1);
  localparam logic [CW-1:0] ARM_LAST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] FIRE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
  typedef enum logic [2:0] {IDLE, ARM, RELEASE, FIRE, CAPTURE, SHIFT} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_d;
  logic [BW-1:0] bcnt, bcnt_d;
  logic [WIDTH-1:0] sr, sr_d;
  logic [7:0] dout_q, dout_d;
  logic busy_q, busy_d, rn_q, rn_d, race_q, race_d, valid_q, valid_d, done_q, done_d;
  logic accept, last;
  assign accept = state == SHIFT && bus.data_ready;
  assign last = bcnt == LAST_BYTE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bcnt <= '0;
      sr <= '0;
      dout_q <= '0;
      busy_q <= 1'b0;
      rn_q <= 1'b0;
      race_q <= 1'b0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_d;
      bcnt <= bcnt_d;
      sr <= sr_d;
      dout_q <= dout_d;
      busy_q <= busy_d;
      rn_q <= rn_d;
      race_q <= race_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? ARM : IDLE;
      ARM:     nxt = cnt == ARM_LAST ? RELEASE : ARM;
      RELEASE: nxt = FIRE;
      FIRE:    nxt = cnt == FIRE_LAST ? CAPTURE : FIRE;
      CAPTURE: nxt = SHIFT;
      SHIFT:   nxt = accept && last ? IDLE : SHIFT;
      default: nxt = IDLE;
    endcase
  end
  // Output flops are loaded from the next state so every pin is registered yet aligned to the state change.
  always_comb begin
    cnt_d = nxt == state && (state == ARM || state == FIRE) ? cnt + CW'(1) : '0;
    bcnt_d = state == SHIFT ? (accept ? bcnt + BW'(1) : bcnt) : '0;
    sr_d = state == CAPTURE ? bus.puf_out : accept ? sr >> 8 : sr;
    dout_d = state == CAPTURE || accept ? sr_d[7:0] : dout_q;
    busy_d = nxt != IDLE;
    rn_d = nxt == RELEASE || nxt == FIRE || nxt == CAPTURE;
    race_d = nxt == FIRE || nxt == CAPTURE;
    valid_d = nxt == SHIFT;
    done_d = accept && last;
  end
  assign bus.busy = busy_q;
  assign bus.puf_rn = rn_q;
  assign bus.puf_i1 = race_q;
  assign bus.puf_i2 = race_q;
  assign bus.data_out = dout_q;
  assign bus.data_valid = valid_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_puf_xor_eval_ctrl.sv
// tb_puf_xor_eval_ctrl: directed vectors and corner sequences for the XOR PUF evaluation controller
module tb_puf_xor_eval_ctrl;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  puf_xor_eval_ctrl_if #(.WIDTH(128)) bus();
  puf_xor_eval_ctrl_if #(.WIDTH(8)) sbus();
  puf_xor_eval_ctrl #(.WIDTH(128), .RST_CYC(4), .SETTLE_CYC(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  puf_xor_eval_ctrl #(.WIDTH(8), .RST_CYC(1), .SETTLE_CYC(1)) sdut (.clk(clk), .rst(rst), .bus(sbus));
  // mode: 0 ready always, 1 ready toggles, 2 ready always plus START pulses while busy, 3 ready held low until k=19
  typedef struct {
    logic [127:0] puf;
    int mode;
    int exp_valid;
    int exp_done;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;
  vec_t vecs[4];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic run_vec(input vec_t v);
    int k = 0, got = 0, dones = 0, fv = -1, dc = -1;
    logic [7:0] first_b = '0, last_b = '0;
    bus.puf_out = v.puf;
    bus.data_ready = 1'b0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    while (k < 100 && dones == 0) begin
      if (k <= 14) begin
        chk("puf_rn", bus.puf_rn, k >= 4 && k < 14);
        chk("puf_i1", bus.puf_i1, k >= 5 && k < 14);
        chk("puf_i2", bus.puf_i2, k >= 5 && k < 14);
        chk("busy", bus.busy, 1);
      end
      if (bus.done) begin
        dones++;
        dc = k;
      end
      if (bus.data_valid && fv < 0) fv = k;
      bus.start = v.mode == 2 && (k == 2 || k == 8 || k == 20);
      bus.data_ready = v.mode == 1 ? k % 2 == 0 : v.mode == 3 ? k >= 19 : 1'b1;
      if (bus.data_valid) begin
        chk("byte", bus.data_out, v.puf[8*got +: 8]);
        if (bus.data_ready) begin
          if (got == 0) first_b = bus.data_out;
          if (got == 15) last_b = bus.data_out;
          got++;
        end
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    bus.data_ready = 1'b0;
    chk("accepts", got, 16);
    chk("done_count", dones, 1);
    chk("first_valid_cycle", fv, v.exp_valid);
    chk("done_cycle", dc, v.exp_done);
    chk("first_byte", first_b, v.exp_first);
    chk("last_byte", last_b, v.exp_last);
    repeat (3) begin
      chk("idle_busy", bus.busy, 0);
      chk("no_extra_done", bus.done, 0);
      @(negedge clk);
    end
  endtask
  task automatic abort_at(input int kt, input string name);
    bus.puf_out = vecs[0].puf;
    bus.data_ready = 1'b1;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (kt) @(negedge clk);
    if (kt == 19) chk({name, "_pre_byte"}, bus.data_out, 8'h05);
    else chk({name, "_pre_fire"}, bus.puf_i1, 1);
    #2 rst = 1'b1;
    #1;
    chk({name, "_i1"}, bus.puf_i1, 0);
    chk({name, "_i2"}, bus.puf_i2, 0);
    chk({name, "_rn"}, bus.puf_rn, 0);
    chk({name, "_valid"}, bus.data_valid, 0);
    chk({name, "_busy"}, bus.busy, 0);
    chk({name, "_data"}, bus.data_out, 0);
    @(negedge clk) rst = 1'b0;
    bus.data_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk({name, "_no_done"}, bus.done, 0);
      chk({name, "_idle"}, bus.busy, 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int k, fv, dc;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.data_ready = 1'b0;
    bus.puf_out = '0;
    sbus.start = 1'b0;
    sbus.data_ready = 1'b0;
    sbus.puf_out = '0;
    vecs[0] = '{128'h0F0E0D0C0B0A09080706050403020100, 0, 14, 30, 8'h00, 8'h0F};
    vecs[1] = '{128'hFFEEDDCCBBAA99887766554433221100, 1, 14, 45, 8'h00, 8'hFF};
    vecs[2] = '{128'h0123456789ABCDEFFEDCBA9876543210, 2, 14, 30, 8'h10, 8'h01};
    vecs[3] = '{128'h80000000000000000000000000000001, 3, 14, 35, 8'h01, 8'h80};
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rn", bus.puf_rn, 0);
    chk("rst_i1", bus.puf_i1, 0);
    chk("rst_i2", bus.puf_i2, 0);
    chk("rst_valid", bus.data_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_data", bus.data_out, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);
    abort_at(8, "abort_fire");
    abort_at(19, "abort_shift");
    run_vec(vecs[0]);
    sbus.puf_out = 8'hA5;
    sbus.data_ready = 1'b1;
    @(negedge clk) sbus.start = 1'b1;
    @(negedge clk) sbus.start = 1'b0;
    k = 0;
    fv = -1;
    dc = -1;
    while (k < 20 && dc < 0) begin
      if (sbus.done) dc = k;
      if (sbus.data_valid && fv < 0) begin
        fv = k;
        chk("small_byte", sbus.data_out, 8'hA5);
      end
      @(negedge clk);
      k++;
    end
    chk("small_first_valid", fv, 4);
    chk("small_done_cycle", dc, 5);
    chk("small_idle", sbus.busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
